// File: rtl/convst_pulse_generator_pkg.sv
// Shared ADC-side constants: strobe FSM encoding and down-counter width.
package convst_pulse_generator_pkg;

    // Width of the strobe/hold-off down-counter
    localparam int unsigned CNT8_W = 8;

    // FSM encoding; the unused code 2'd3 recovers to idle
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOW  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

endpackage

// File: rtl/convst_pulse_generator.sv
// Turns a one-clock trigger into a fixed-width active-low CONVST strobe
// followed by a forced-high hold-off, with busy/done/overrun/count status.
module convst_pulse_generator
    import convst_pulse_generator_pkg::*;
#(
    parameter int unsigned PULSE_WIDTH = 4,
    parameter int unsigned HOLDOFF     = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             trigger,
    input  logic             overrun_clr,
    output logic             convst_n,
    output logic             busy,
    output logic             done,
    output logic             overrun,
    output logic [CNT_W-1:0] strobe_count
);

    // Out-of-range timing parameters cannot be represented by the 8-bit counter
    generate
        if (PULSE_WIDTH < 1 || PULSE_WIDTH > 255 || HOLDOFF > 255) begin : g_bad_param
            $fatal(1, "convst_pulse_generator: illegal PULSE_WIDTH/HOLDOFF");
        end
    endgenerate

    localparam logic [CNT8_W-1:0] PW_LOAD  = CNT8_W'(PULSE_WIDTH - 1);
    localparam logic [CNT8_W-1:0] HO_LOAD  = CNT8_W'(HOLDOFF - 1);
    localparam bit                HAS_HOLD = (HOLDOFF != 0);

    logic [1:0]        state_q, state_d;
    logic [CNT8_W-1:0] cnt_q, cnt_d;
    logic              convst_n_d, busy_d, done_d, overrun_d;
    logic [CNT_W-1:0]  strobe_count_d;

    // FSM, down-counter and all output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            convst_n     <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            overrun      <= 1'b0;
            strobe_count <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            convst_n     <= convst_n_d;
            busy         <= busy_d;
            done         <= done_d;
            overrun      <= overrun_d;
            strobe_count <= strobe_count_d;
        end
    end

    // Next-state and next-output logic; a dropped trigger beats overrun_clr
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        convst_n_d     = convst_n;
        busy_d         = busy;
        done_d         = 1'b0;
        overrun_d      = overrun & ~overrun_clr;
        strobe_count_d = strobe_count;

        case (state_q)
            ST_IDLE: begin
                convst_n_d = 1'b1;
                busy_d     = 1'b0;
                if (trigger) begin
                    state_d        = ST_LOW;
                    convst_n_d     = 1'b0;
                    busy_d         = 1'b1;
                    cnt_d          = PW_LOAD;
                    strobe_count_d = strobe_count + CNT_W'(1);
                end
            end
            ST_LOW: begin
                if (trigger) begin
                    overrun_d = 1'b1;
                end
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT8_W'(1);
                end else if (HAS_HOLD) begin
                    state_d    = ST_HOLD;
                    convst_n_d = 1'b1;
                    cnt_d      = HO_LOAD;
                end else begin
                    state_d    = ST_IDLE;
                    convst_n_d = 1'b1;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                end
            end
            ST_HOLD: begin
                if (trigger) begin
                    overrun_d = 1'b1;
                end
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT8_W'(1);
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                cnt_d      = '0;
                convst_n_d = 1'b1;
                busy_d     = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_convst_pulse_generator.sv
// Bench for convst_pulse_generator: a timing-formula model pushes the expected
// outputs of every cycle into a queue; each scenario pops and compares them.
module tb_convst_pulse_generator;

    typedef struct packed {
        logic        convst_n;
        logic        busy;
        logic        done;
        logic        overrun;
        logic [15:0] count;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        trigger = 1'b0;
    logic        overrun_clr = 1'b0;

    logic        a_convst_n, a_busy, a_done, a_overrun;
    logic [15:0] a_count;
    logic        b_convst_n, b_busy, b_done, b_overrun;
    logic [15:0] b_count;
    logic        c_convst_n, c_busy, c_done, c_overrun;
    logic [3:0]  c_count;

    int passed = 0;
    int checks = 0;

    // Model state (times in cycles after the last reset)
    int m_cyc, m_next_ok, m_low_s, m_low_e, m_busy_e, m_done_c, m_cnt;
    int m_pw, m_ho, m_cw, sel;
    logic m_ovr;
    obs_t exp_q[$];
    obs_t got, exp_v;

    always #5 clk = ~clk;

    convst_pulse_generator #(.PULSE_WIDTH(4), .HOLDOFF(2), .CNT_W(16)) u_def (
        .clk(clk), .rst_n(rst_n), .trigger(trigger), .overrun_clr(overrun_clr),
        .convst_n(a_convst_n), .busy(a_busy), .done(a_done), .overrun(a_overrun),
        .strobe_count(a_count));

    convst_pulse_generator #(.PULSE_WIDTH(1), .HOLDOFF(0), .CNT_W(16)) u_fast (
        .clk(clk), .rst_n(rst_n), .trigger(trigger), .overrun_clr(overrun_clr),
        .convst_n(b_convst_n), .busy(b_busy), .done(b_done), .overrun(b_overrun),
        .strobe_count(b_count));

    convst_pulse_generator #(.PULSE_WIDTH(4), .HOLDOFF(2), .CNT_W(4)) u_c4 (
        .clk(clk), .rst_n(rst_n), .trigger(trigger), .overrun_clr(overrun_clr),
        .convst_n(c_convst_n), .busy(c_busy), .done(c_done), .overrun(c_overrun),
        .strobe_count(c_count));

    // Current outputs of the instance under test
    function automatic obs_t sample();
        obs_t o;
        case (sel)
            1:       o = '{b_convst_n, b_busy, b_done, b_overrun, b_count};
            2:       o = '{c_convst_n, c_busy, c_done, c_overrun, 16'(c_count)};
            default: o = '{a_convst_n, a_busy, a_done, a_overrun, a_count};
        endcase
        return o;
    endfunction

    // Assert reset, release it away from the clock edge and clear the model
    task automatic do_reset(input int pw, input int ho, input int cw, input int s);
        trigger = 1'b0;
        overrun_clr = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_pw = pw; m_ho = ho; m_cw = cw; sel = s;
        m_cyc = 0; m_next_ok = 0; m_cnt = 0; m_ovr = 1'b0;
        m_low_s = -100; m_low_e = -100; m_busy_e = -100; m_done_c = -100;
        exp_q.delete();
    endtask

    // Drive one cycle of stimulus and push the expected outputs of the next cycle
    task automatic step(input logic trig, input logic clr);
        obs_t e;
        int c;
        trigger = trig;
        overrun_clr = clr;
        if (trig && m_cyc >= m_next_ok) begin
            m_low_s  = m_cyc + 1;
            m_low_e  = m_cyc + m_pw;
            m_busy_e = m_cyc + m_pw + m_ho;
            m_done_c = m_busy_e + 1;
            m_next_ok = m_done_c;
            m_cnt++;
            if (clr) m_ovr = 1'b0;
        end else if (trig) begin
            m_ovr = 1'b1;
        end else if (clr) begin
            m_ovr = 1'b0;
        end
        c = m_cyc + 1;
        e.convst_n = !(c >= m_low_s && c <= m_low_e);
        e.busy     = (c >= m_low_s && c <= m_busy_e);
        e.done     = (c == m_done_c);
        e.overrun  = m_ovr;
        e.count    = 16'(m_cnt & ((1 << m_cw) - 1));
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        m_cyc++;
        trigger = 1'b0;
        overrun_clr = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(4, 2, 16, 0);
        got = sample();
        checks++;
        if (got !== obs_t'{1'b1, 1'b0, 1'b0, 1'b0, 16'd0})
            $display("FAIL reset_state got=%h exp=%h", got, obs_t'{1'b1, 1'b0, 1'b0, 1'b0, 16'd0});
        else passed++;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0);
            exp_v = exp_q.pop_front();
            got = sample();
            checks++;
            if (got !== exp_v) $display("FAIL reset_idle cyc=%0d got=%h exp=%h", m_cyc, got, exp_v);
            else passed++;
        end
    endtask

    task automatic test_single();
        do_reset(4, 2, 16, 0);
        for (int i = 0; i < 16; i++) begin
            step(i == 5, 1'b0);
            exp_v = exp_q.pop_front();
            got = sample();
            checks++;
            if (got !== exp_v) $display("FAIL single cyc=%0d got=%h exp=%h", m_cyc, got, exp_v);
            else passed++;
        end
        checks++;
        if (got.count !== 16'd1) $display("FAIL single_count got=%0d exp=1", got.count);
        else passed++;
    endtask

    task automatic test_drop();
        do_reset(4, 2, 16, 0);
        for (int i = 0; i < 20; i++) begin
            step(i == 5 || i == 10 || i == 12, 1'b0);
            exp_v = exp_q.pop_front();
            got = sample();
            checks++;
            if (got !== exp_v) $display("FAIL drop cyc=%0d got=%h exp=%h", m_cyc, got, exp_v);
            else passed++;
            if (m_cyc == 11) begin
                checks++;
                if (got.overrun !== 1'b1 || got.count !== 16'd1)
                    $display("FAIL drop_flag ovr=%b cnt=%0d exp ovr=1 cnt=1", got.overrun, got.count);
                else passed++;
            end
        end
        checks++;
        if (got.count !== 16'd2) $display("FAIL drop_count got=%0d exp=2", got.count);
        else passed++;
    endtask

    task automatic test_back_to_back();
        do_reset(1, 0, 16, 1);
        for (int i = 0; i < 10; i++) begin
            step(i < 6, 1'b0);
            exp_v = exp_q.pop_front();
            got = sample();
            checks++;
            if (got !== exp_v) $display("FAIL b2b cyc=%0d got=%h exp=%h", m_cyc, got, exp_v);
            else passed++;
        end
        checks++;
        if (got.count !== 16'd3 || got.overrun !== 1'b1)
            $display("FAIL b2b_final cnt=%0d ovr=%b exp cnt=3 ovr=1", got.count, got.overrun);
        else passed++;
    endtask

    task automatic test_overrun_clr();
        do_reset(4, 2, 16, 0);
        for (int i = 0; i < 8; i++) begin
            step(i == 0 || i == 2 || i == 3, i == 3 || i == 4);
            exp_v = exp_q.pop_front();
            got = sample();
            checks++;
            if (got !== exp_v) $display("FAIL ovr_clr cyc=%0d got=%h exp=%h", m_cyc, got, exp_v);
            else passed++;
            if (m_cyc == 4) begin
                checks++;
                if (got.overrun !== 1'b1) $display("FAIL ovr_set_wins got=%b exp=1", got.overrun);
                else passed++;
            end
            if (m_cyc == 5) begin
                checks++;
                if (got.overrun !== 1'b0) $display("FAIL ovr_cleared got=%b exp=0", got.overrun);
                else passed++;
            end
        end
    endtask

    task automatic test_reset_mid_strobe();
        do_reset(4, 2, 16, 0);
        step(1'b1, 1'b0);
        void'(exp_q.pop_front());
        step(1'b0, 1'b0);
        exp_v = exp_q.pop_front();
        got = sample();
        checks++;
        if (got !== exp_v) $display("FAIL mid_pre got=%h exp=%h", got, exp_v);
        else passed++;
        rst_n = 1'b0;
        #1;
        got = sample();
        checks++;
        if (got.convst_n !== 1'b1 || got.busy !== 1'b0)
            $display("FAIL mid_async convst_n=%b busy=%b exp 1 0", got.convst_n, got.busy);
        else passed++;
        do_reset(4, 2, 16, 0);
        for (int i = 0; i < 10; i++) begin
            step(i == 1, 1'b0);
            exp_v = exp_q.pop_front();
            got = sample();
            checks++;
            if (got !== exp_v) $display("FAIL mid_after cyc=%0d got=%h exp=%h", m_cyc, got, exp_v);
            else passed++;
        end
    endtask

    task automatic test_wrap();
        do_reset(4, 2, 4, 2);
        for (int t = 0; t < 16; t++) begin
            for (int i = 0; i < 7; i++) begin
                step(i == 0, 1'b0);
                exp_v = exp_q.pop_front();
                got = sample();
                checks++;
                if (got !== exp_v) $display("FAIL wrap cyc=%0d got=%h exp=%h", m_cyc, got, exp_v);
                else passed++;
            end
        end
        checks++;
        if (got.count !== 16'd0 || got.overrun !== 1'b0)
            $display("FAIL wrap_final cnt=%0d ovr=%b exp cnt=0 ovr=0", got.count, got.overrun);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_drop();
        test_back_to_back();
        test_overrun_clr();
        test_reset_mid_strobe();
        test_wrap();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
